// File: rtl/clk_div_sched.sv
// clk_div_sched: programmable integer clock divider with glitch-free ratio
// switching and start/stop sequencing. Ratio changes and disables only take
// effect at period boundaries, so o_clk_div never shows a runt pulse.
//
// Optional build macro: CLK_DIV_SCHED_ODD50_EN
//   defined   -> odd ratios get exactly 50% duty via a negedge-clocked copy
//                of the divided clock ORed into the output.
//   undefined -> posedge-only logic; odd ratios are high for ceil(N/2) cycles.
module clk_div_sched #(
    parameter int unsigned W       = 10,
    parameter int unsigned RST_DIV = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_b,
    input  logic         i_en,
    input  logic         i_cfg_valid,
    input  logic [W-1:0] i_cfg_div,
    output logic         o_cfg_ready,
    output logic         o_clk_div,
    output logic         o_busy,
    output logic         o_switch_done,
    output logic         o_err
);

    localparam logic [W-1:0] DIV_ONE = W'(1);
    localparam logic [W-1:0] DIV_MIN = W'(2);
    localparam logic [W-1:0] DIV_RST = W'(RST_DIV);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   div_q, div_d;
    logic           pend_q, pend_d;
    logic [W-1:0]   pdiv_q, pdiv_d;
    logic           clk_q, clk_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           accept;
    logic           apply;
    logic           boundary;
    logic [W-1:0]   high_d;

    // State, counter, ratio and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            div_q   <= DIV_RST;
            pend_q  <= 1'b0;
            pdiv_q  <= '0;
            clk_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            pdiv_q  <= pdiv_d;
            clk_q   <= clk_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state: sequencing, ratio handshake/apply and divided-clock level
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        pend_d   = pend_q;
        pdiv_d   = pdiv_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        apply    = 1'b0;
        accept   = i_cfg_valid && ready_q;
        boundary = (cnt_q == (div_q - DIV_ONE));

        unique case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                apply = pend_q;
                if (i_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    cnt_d = '0;
                    apply = pend_q;
                    if (!i_en) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end
            ST_DRAIN: begin
                cnt_d   = '0;
                apply   = pend_q;
                state_d = i_en ? ST_RUN : ST_OFF;
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        // Pending ratio is only observed from the register, so a request
        // accepted on a boundary edge waits for the following boundary.
        if (apply) begin
            pend_d = 1'b0;
            if (pdiv_q >= DIV_MIN) begin
                div_d  = pdiv_q;
                done_d = 1'b1;
            end else begin
                err_d  = 1'b1;
            end
        end

        if (accept) begin
            pend_d = 1'b1;
            pdiv_d = i_cfg_div;
        end

        // Entering RUN parks the counter on the last (low) count so the
        // first full period begins on the following edge.
        if ((state_q != ST_RUN) && (state_d == ST_RUN)) begin
            cnt_d = div_d - DIV_ONE;
        end

        ready_d = !pend_q && !accept;
        busy_d  = (state_d != ST_OFF);

`ifdef CLK_DIV_SCHED_ODD50_EN
        high_d = div_d >> 1;
`else
        high_d = (div_d >> 1) + W'(div_d[0]);
`endif
        clk_d = (state_d == ST_RUN) && (cnt_d < high_d);
    end

`ifdef CLK_DIV_SCHED_ODD50_EN
    logic neg_q;

    // Half-cycle delayed copy stretches odd-ratio high time by half a cycle
    always_ff @(negedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= clk_q & div_q[0];
        end
    end

    assign o_clk_div = clk_q | neg_q;
`else
    assign o_clk_div = clk_q;
`endif

    assign o_cfg_ready   = ready_q;
    assign o_busy        = busy_q;
    assign o_switch_done = done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched (default build). Stimulus pushes
// per-cycle expected {clk_div, cfg_ready, busy} samples and expected
// switch/err events; a monitor pops and compares on every falling edge.
module tb_clk_div_sched;

    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         clk_div;
    logic         busy;
    logic         sw_done;
    logic         err;

    always #5 clk = ~clk;

    clk_div_sched #(.W(W), .RST_DIV(2)) dut (
        .i_clk         (clk),
        .i_rst_b       (rst_b),
        .i_en          (en),
        .i_cfg_valid   (cfg_valid),
        .i_cfg_div     (cfg_div),
        .o_cfg_ready   (cfg_ready),
        .o_clk_div     (clk_div),
        .o_busy        (busy),
        .o_switch_done (sw_done),
        .o_err         (err)
    );

    typedef struct packed {
        logic [2:0] val;
        logic [2:0] msk;
    } samp_t;

    samp_t      sq[$];
    logic [1:0] eq[$];
    int         total = 0;
    int         bad   = 0;

    localparam logic [1:0] EV_DONE = 2'b01;
    localparam logic [1:0] EV_ERR  = 2'b10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each string character is one cycle: '1', '0' or 'x' (don't care)
    task automatic push_s(input string c, input string r, input string b);
        for (int i = 0; i < c.len(); i++) begin
            samp_t s;
            s.val = {c[i] == "1", r[i] == "1", b[i] == "1"};
            s.msk = {c[i] != "x", r[i] != "x", b[i] != "x"};
            sq.push_back(s);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle waveform samples and switch/err events
    initial begin
        int n;
        samp_t s;
        logic [1:0] e;
        n = 0;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                s = sq.pop_front();
                check($sformatf("wave[%0d] {clk,rdy,busy}", n),
                      32'({clk_div, cfg_ready, busy} & s.msk), 32'(s.val & s.msk));
                n++;
            end
            if (sw_done || err) begin
                if (eq.size() == 0) begin
                    check("unexpected event {err,done}", 32'({err, sw_done}), 32'(0));
                end else begin
                    e = eq.pop_front();
                    check("event {err,done}", 32'({err, sw_done}), 32'(e));
                end
            end
        end
    end

    initial begin
        rst_b     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        tick(2);

        // Reset values
        check("rst clk_div", 32'(clk_div), 32'(0));
        check("rst ready",   32'(cfg_ready), 32'(1));
        check("rst busy",    32'(busy), 32'(0));
        check("rst done",    32'(sw_done), 32'(0));
        check("rst err",     32'(err), 32'(0));
        rst_b = 1'b1;
        for (int i = 0; i < 20; i++) push_s("0", "1", "0");
        tick(20);

        // Program N=4 while OFF: applied the edge after acceptance
        cfg_valid = 1'b1;
        cfg_div   = 10'd4;
        eq.push_back(EV_DONE);
        push_s("0000", "1001", "0000");
        tick(1);
        cfg_valid = 1'b0;
        tick(3);

        // Enable: 1100 repeating, first 1 one edge after en is sampled
        en = 1'b1;
        push_s("00110011001100", "11111111111111", "01111111111111");
        tick(14);

        // Switch to N=5 at start of a period: 11100
        cfg_valid = 1'b1;
        cfg_div   = 10'd5;
        eq.push_back(EV_DONE);
        push_s("11001110011100", "10000111111111", "11111111111111");
        tick(1);
        cfg_valid = 1'b0;
        tick(13);

        // Go to N=6
        cfg_valid = 1'b1;
        cfg_div   = 10'd6;
        eq.push_back(EV_DONE);
        tick(1);
        cfg_valid = 1'b0;
        tick(5);

        // Mid-period switch N=6 -> N=3 requested at cnt=1
        cfg_valid = 1'b1;
        cfg_div   = 10'd3;
        eq.push_back(EV_DONE);
        push_s("11000110110110", "10000011111111", "11111111111111");
        tick(1);
        cfg_valid = 1'b0;
        tick(13);

        // Reject N=1, then a held second request (N=7) waits for ready
        cfg_valid = 1'b1;
        cfg_div   = 10'd1;
        eq.push_back(EV_ERR);
        eq.push_back(EV_DONE);
        push_s("11011011110001", "10001001111111", "11111111111111");
        tick(1);
        cfg_div = 10'd7;
        tick(4);
        cfg_valid = 1'b0;
        tick(9);

        // Go to N=8, then disable at cnt=2: full period, DRAIN, OFF
        cfg_valid = 1'b1;
        cfg_div   = 10'd8;
        eq.push_back(EV_DONE);
        tick(1);
        cfg_valid = 1'b0;
        tick(7);
        en = 1'b0;
        push_s("110000000000", "111111111111", "111111100000");
        tick(12);

        // Async reset mid-period with a request pending
        en = 1'b1;
        tick(4);
        cfg_valid = 1'b1;
        cfg_div   = 10'd5;
        tick(1);
        cfg_valid = 1'b0;
        check("pre-rst clk_div", 32'(clk_div), 32'(1));
        check("pre-rst ready",   32'(cfg_ready), 32'(0));
        #2;
        rst_b = 1'b0;
        #1;
        check("async rst clk_div", 32'(clk_div), 32'(0));
        check("async rst busy",    32'(busy), 32'(0));
        check("async rst ready",   32'(cfg_ready), 32'(1));
        check("async rst done",    32'(sw_done), 32'(0));
        check("async rst err",     32'(err), 32'(0));
        #4;
        rst_b = 1'b1;

        // Restart at RST_DIV=2; discarded pending ratio never applies
        push_s("01010101", "11111111", "11111111");
        tick(9);

        check("events outstanding",  32'(eq.size()), 32'(0));
        check("samples outstanding", 32'(sq.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
